// File: rtl/mux_n_1_pipe.sv
// mux_n_1_pipe: N-input, W-bit selector feeding a registered output stage
// with a valid/ready handshake, a one-entry skid register and a flush input.
// Optional feature macro: MUX_SEL_CHECK_EN adds the sticky sel_err output
// and a simulation assertion on out-of-range selects.
module mux_n_1_pipe #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic                    sel_err
`endif
);

  // Refuse to elaborate with an input count the select cannot address
  generate
    if (NUM_IN < 2 || NUM_IN > 16 || (2 ** SEL_W) < NUM_IN) begin : g_bad_params
      $error("mux_n_1_pipe: NUM_IN must be 2..16 and 2**SEL_W >= NUM_IN");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  main_data;
  logic [SEL_W-1:0]  main_sel;
  logic [WIDTH-1:0]  skid_data;
  logic [SEL_W-1:0]  skid_sel;
  logic [WIDTH-1:0]  sel_data;
  logic              accept;
  logic              xfer_out;

  // Pick the addressed input slice; an out-of-range select yields zeros
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready  = (state != TWO) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state != EMPTY);
  assign xfer_out  = out_valid && out_ready;
  assign out_data  = main_data;
  assign out_sel   = main_sel;

  // Main/skid pipeline: reset beats flush, flush beats any accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= sel_data;
            main_sel  <= sel;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && xfer_out) begin
            main_data <= sel_data;
            main_sel  <= sel;
          end else if (accept) begin
            skid_data <= sel_data;
            skid_sel  <= sel;
            state     <= TWO;
          end else if (xfer_out) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (xfer_out) begin
            main_data <= skid_data;
            main_sel  <= skid_sel;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic sel_illegal;

  // A fully populated select space can never be out of range
  generate
    if (NUM_IN == (2 ** SEL_W)) begin : g_no_illegal
      assign sel_illegal = 1'b0;
    end else begin : g_illegal
      assign sel_illegal = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
    end
  endgenerate

  // Sticky error flag, raised when an out-of-range select is accepted
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sel_err <= 1'b0;
    end else if (accept && sel_illegal) begin
      sel_err <= 1'b1;
    end
  end

  a_sel_legal: assert property (@(posedge clk) disable iff (rst)
                                !(accept && sel_illegal))
    else $warning("mux_n_1_pipe: accepted out-of-range select %0d", sel);
`endif

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// tb_mux_n_1_pipe: directed checks on a 4-input and a 3-input instance,
// followed by a randomised streaming run against a queue scoreboard.
module tb_mux_n_1_pipe;

  logic        clk = 1'b0;
  logic        rst;

  logic [63:0] in4;
  logic [1:0]  sel4;
  logic        in_valid4, in_ready4, flush4;
  logic [15:0] out_data4;
  logic [1:0]  out_sel4;
  logic        out_valid4, out_ready4;

  logic [47:0] in3;
  logic [1:0]  sel3;
  logic        in_valid3, in_ready3, flush3;
  logic [15:0] out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3, out_ready3;

`ifdef MUX_SEL_CHECK_EN
  logic        sel_err4, sel_err3;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  mux_n_1_pipe #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in4), .sel(sel4), .in_valid(in_valid4),
    .in_ready(in_ready4), .flush(flush4), .out_data(out_data4),
    .out_sel(out_sel4), .out_valid(out_valid4), .out_ready(out_ready4)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(sel_err4)
`endif
  );

  mux_n_1_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in3), .sel(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .flush(flush3), .out_data(out_data3),
    .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(sel_err3)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] s,
                               input logic ready);
    in_valid4  = valid;
    sel4       = s;
    out_ready4 = ready;
  endtask

  logic [17:0] sb_q[$];
  logic [17:0] sb_exp;
  logic [63:0] shifted;
  int pushed, popped, cycles;

  initial begin
    rst = 1'b1;
    in4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    in3 = {16'h3333, 16'h2222, 16'h1111};
    flush4 = 1'b0; flush3 = 1'b0;
    in_valid3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b1);

    // reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready4, 0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", in_ready4, 1);
    checkOutput("idle_out_valid", out_valid4, 0);
    checkOutput("idle_out_data", out_data4, 16'h0000);
    checkOutput("idle_out_sel", out_sel4, 0);

    // basic select, back-to-back
    applyStimulus(1'b1, 2'd2, 1'b1);
    @(negedge clk);
    checkOutput("basic_valid0", out_valid4, 1);
    checkOutput("basic_data0", out_data4, 16'h3333);
    checkOutput("basic_sel0", out_sel4, 2);
    applyStimulus(1'b1, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("basic_data1", out_data4, 16'h1111);
    checkOutput("basic_sel1", out_sel4, 0);
    applyStimulus(1'b0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("basic_drained", out_valid4, 0);

    // back-pressure: A=sel1, B=sel2, C=sel3
    applyStimulus(1'b1, 2'd1, 1'b0);
    @(negedge clk);
    checkOutput("bp_a_valid", out_valid4, 1);
    checkOutput("bp_a_data", out_data4, 16'h2222);
    checkOutput("bp_ready_one", in_ready4, 1);
    applyStimulus(1'b1, 2'd2, 1'b0);
    @(negedge clk);
    checkOutput("bp_a_held", out_data4, 16'h2222);
    checkOutput("bp_a_sel_held", out_sel4, 1);
    checkOutput("bp_ready_two", in_ready4, 0);
    applyStimulus(1'b1, 2'd3, 1'b0);
    @(negedge clk);
    checkOutput("bp_a_still", out_data4, 16'h2222);
    checkOutput("bp_c_blocked", in_ready4, 0);
    applyStimulus(1'b1, 2'd3, 1'b1);
    @(negedge clk);
    checkOutput("bp_b_data", out_data4, 16'h3333);
    checkOutput("bp_b_sel", out_sel4, 2);
    checkOutput("bp_ready_back", in_ready4, 1);
    @(negedge clk);
    checkOutput("bp_c_data", out_data4, 16'h4444);
    checkOutput("bp_c_sel", out_sel4, 3);
    applyStimulus(1'b0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("bp_drained", out_valid4, 0);

    // flush in TWO with a simultaneous in_valid
    applyStimulus(1'b1, 2'd0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 2'd1, 1'b0);
    @(negedge clk);
    checkOutput("fl_two_ready", in_ready4, 0);
    flush4 = 1'b1;
    applyStimulus(1'b1, 2'd2, 1'b0);
    @(negedge clk);
    checkOutput("fl_two_valid", out_valid4, 0);
    checkOutput("fl_two_ready_after", in_ready4, 1);
    flush4 = 1'b0;
    applyStimulus(1'b1, 2'd3, 1'b0);
    @(negedge clk);
    checkOutput("fl_next_data", out_data4, 16'h4444);
    checkOutput("fl_next_sel", out_sel4, 3);
    // flush in ONE while accepting and transferring out
    flush4 = 1'b1;
    applyStimulus(1'b1, 2'd2, 1'b1);
    @(negedge clk);
    checkOutput("fl_one_valid", out_valid4, 0);
    flush4 = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("fl_no_ghost", out_valid4, 0);

    // reset mid-transfer discards the held item
    applyStimulus(1'b1, 2'd1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_ready", in_ready4, 0);
    @(negedge clk);
    checkOutput("rst_mid_valid", out_valid4, 0);
    checkOutput("rst_mid_data", out_data4, 16'h0000);
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("rst_mid_idle", out_valid4, 0);

    // illegal select on the 3-input instance
    in_valid3 = 1'b1; sel3 = 2'd3; out_ready3 = 1'b1;
    @(negedge clk);
    checkOutput("ill_valid", out_valid3, 1);
    checkOutput("ill_data", out_data3, 16'h0000);
    checkOutput("ill_sel", out_sel3, 3);
`ifdef MUX_SEL_CHECK_EN
    checkOutput("ill_err_set", sel_err3, 1);
`endif
    sel3 = 2'd2;
    @(negedge clk);
    checkOutput("leg3_data", out_data3, 16'h3333);
`ifdef MUX_SEL_CHECK_EN
    checkOutput("ill_err_sticky", sel_err3, 1);
`endif
    in_valid3 = 1'b0;
    @(negedge clk);
    checkOutput("ill_drained", out_valid3, 0);
    flush3 = 1'b1;
    @(negedge clk);
    flush3 = 1'b0;
`ifdef MUX_SEL_CHECK_EN
    checkOutput("ill_err_cleared", sel_err3, 0);
`endif
    checkOutput("ill_flush_ready", in_ready3, 1);

    // random streaming against a scoreboard
    pushed = 0; popped = 0; cycles = 0;
    while (popped < 1000 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      in4 = {$urandom(), $urandom()};
      applyStimulus(pushed < 1000 && ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
      #1;
      if (out_valid4 && out_ready4) begin
        if (sb_q.size() == 0) begin
          checkOutput("stream_underflow", 1, 0);
        end else begin
          sb_exp = sb_q.pop_front();
          checkOutput("stream_item", {14'd0, out_sel4, out_data4}, {14'd0, sb_exp});
        end
        popped++;
      end
      if (in_valid4 && in_ready4) begin
        shifted = in4 >> (32'(sel4) * 16);
        sb_q.push_back({sel4, shifted[15:0]});
        pushed++;
      end
    end
    checkOutput("stream_count", popped, 1000);
    applyStimulus(1'b0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("stream_drained", out_valid4, 0);
    checkOutput("stream_queue_empty", sb_q.size(), 0);
`ifdef MUX_SEL_CHECK_EN
    checkOutput("full_space_no_err", sel_err4, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
